// File: rtl/blink_rate_meter.sv
// Blink rate meter: measures the period of a blinking input in clocks and classifies it as 10/5/2/1 Hz.
// Optional high-time measurement enabled by defining BLINK_RATE_METER_DUTY_EN.
module blink_rate_meter #(
    parameter int g_COUNT_10HZ = 1250000,
    parameter int g_COUNT_5HZ  = 2500000,
    parameter int g_COUNT_2HZ  = 6250000,
    parameter int g_COUNT_1HZ  = 12500000,
    parameter int g_TOL_SHIFT  = 4,
    parameter int g_TIMEOUT    = 50000000,
    parameter int g_CNT_W      = 26
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Signal,
    output logic [g_CNT_W-1:0] o_Period,
    output logic               o_Valid,
    output logic [2:0]         o_Rate,
    output logic               o_Timeout,
    output logic [g_CNT_W-1:0] o_High_Time
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_STALLED = 2'd2
    } state_t;

    localparam logic [g_CNT_W:0]   E_10HZ    = (g_CNT_W+1)'(2 * g_COUNT_10HZ);
    localparam logic [g_CNT_W:0]   E_5HZ     = (g_CNT_W+1)'(2 * g_COUNT_5HZ);
    localparam logic [g_CNT_W:0]   E_2HZ     = (g_CNT_W+1)'(2 * g_COUNT_2HZ);
    localparam logic [g_CNT_W:0]   E_1HZ     = (g_CNT_W+1)'(2 * g_COUNT_1HZ);
    localparam logic [g_CNT_W-1:0] TIMEOUT_C = g_CNT_W'(g_TIMEOUT);
    localparam logic [g_CNT_W-1:0] ONE_C     = {{(g_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [g_CNT_W-1:0] ZERO_C    = {g_CNT_W{1'b0}};

    // One extra bit keeps the absolute difference free of wrap-around.
    function automatic logic within_tol(input logic [g_CNT_W:0] p, input logic [g_CNT_W:0] e);
        logic [g_CNT_W:0] diff;
        if (p >= e) begin
            diff = p - e;
        end else begin
            diff = e - p;
        end
        return (diff <= (e >> g_TOL_SHIFT));
    endfunction

    function automatic logic [2:0] classify(input logic [g_CNT_W-1:0] p);
        logic [g_CNT_W:0] p_ext;
        logic [2:0]       rate;
        p_ext = {1'b0, p};
        if (within_tol(p_ext, E_10HZ)) begin
            rate = 3'd1;
        end else if (within_tol(p_ext, E_5HZ)) begin
            rate = 3'd2;
        end else if (within_tol(p_ext, E_2HZ)) begin
            rate = 3'd3;
        end else if (within_tol(p_ext, E_1HZ)) begin
            rate = 3'd4;
        end else begin
            rate = 3'd0;
        end
        return rate;
    endfunction

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    logic [g_CNT_W-1:0] count_q, count_d;
    logic [g_CNT_W-1:0] period_q, period_d;
    logic [2:0]         rate_q, rate_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic               rise_s, at_limit_s, report_s, stall_s;

    // Synchronizer, period counter, state machine and result registers (next-state)
    always_comb begin
        sync1_d    = i_Signal;
        sync2_d    = sync1_q;
        dly_d      = sync2_q;
        rise_s     = sync2_q & ~dly_q;
        at_limit_s = (count_q == TIMEOUT_C);
        state_d    = state_q;
        period_d   = period_q;
        rate_d     = rate_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;
        report_s   = 1'b0;
        stall_s    = 1'b0;

        if (rise_s) begin
            count_d = ONE_C;
        end else if (!at_limit_s) begin
            count_d = count_q + ONE_C;
        end else begin
            count_d = count_q;
        end

        // An edge always wins over a simultaneous timeout.
        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    state_d = S_MEASURE;
                end else if (at_limit_s) begin
                    stall_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEASURE: begin
                if (rise_s) begin
                    report_s = 1'b1;
                end else if (at_limit_s) begin
                    stall_s = 1'b1;
                end else begin
                    state_d = S_MEASURE;
                end
            end
            S_STALLED: begin
                if (rise_s) begin
                    state_d = S_MEASURE;
                end else begin
                    state_d = S_STALLED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (report_s) begin
            period_d  = count_q;
            rate_d    = classify(count_q);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
        end else if (stall_s) begin
            state_d   = S_STALLED;
            period_d  = ZERO_C;
            rate_d    = 3'd0;
            timeout_d = 1'b1;
        end else begin
            valid_d   = 1'b0;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dly_q     <= 1'b0;
            count_q   <= ZERO_C;
            period_q  <= ZERO_C;
            rate_q    <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dly_q     <= dly_d;
            count_q   <= count_d;
            period_q  <= period_d;
            rate_q    <= rate_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Period  = period_q;
    assign o_Rate    = rate_q;
    assign o_Valid   = valid_q;
    assign o_Timeout = timeout_q;

`ifdef BLINK_RATE_METER_DUTY_EN
    logic [g_CNT_W-1:0] hi_cnt_q, hi_cnt_d, hi_meas_q, hi_meas_d, high_q, high_d;
    logic               fall_s;

    // High-phase counter: latched at the falling edge, published with the period report
    always_comb begin
        fall_s    = ~sync2_q & dly_q;
        hi_meas_d = hi_meas_q;
        if (rise_s) begin
            hi_cnt_d = ONE_C;
        end else if (sync2_q && dly_q && (hi_cnt_q != TIMEOUT_C)) begin
            hi_cnt_d = hi_cnt_q + ONE_C;
        end else begin
            hi_cnt_d = hi_cnt_q;
        end
        if (fall_s) begin
            hi_meas_d = hi_cnt_q;
        end else begin
            hi_meas_d = hi_meas_q;
        end
        if (report_s) begin
            high_d = hi_meas_q;
        end else if (stall_s) begin
            high_d = ZERO_C;
        end else begin
            high_d = high_q;
        end
    end

    // High-time registers with synchronous reset
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hi_cnt_q  <= ZERO_C;
            hi_meas_q <= ZERO_C;
            high_q    <= ZERO_C;
        end else begin
            hi_cnt_q  <= hi_cnt_d;
            hi_meas_q <= hi_meas_d;
            high_q    <= high_d;
        end
    end

    assign o_High_Time = high_q;
`else
    assign o_High_Time = ZERO_C;
`endif

endmodule

// File: tb/tb_blink_rate_meter.sv
// Scoreboard bench for blink_rate_meter: randomized square waves checked against a period/rate reference model.
module tb_blink_rate_meter;

    localparam int C10 = 5, C5 = 10, C2 = 25, C1 = 50;
    localparam int TOL_SHIFT = 2, TIMEOUT = 200, CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig = 1'b0;
    logic [CNT_W-1:0] o_period, o_high_time;
    logic             o_valid, o_timeout;
    logic [2:0]       o_rate;

    typedef struct {
        int period;
        int rate;
        int high;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   armed = 1'b0;
    int   prev_p = 0;
    int   prev_h = 0;

    blink_rate_meter #(
        .g_COUNT_10HZ(C10), .g_COUNT_5HZ(C5), .g_COUNT_2HZ(C2), .g_COUNT_1HZ(C1),
        .g_TOL_SHIFT(TOL_SHIFT), .g_TIMEOUT(TIMEOUT), .g_CNT_W(CNT_W)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Signal(sig),
        .o_Period(o_period), .o_Valid(o_valid), .o_Rate(o_rate),
        .o_Timeout(o_timeout), .o_High_Time(o_high_time)
    );

    always #5 clk = ~clk;

    function automatic int ref_rate(int p);
        int e[4];
        e = '{2*C10, 2*C5, 2*C2, 2*C1};
        for (int i = 0; i < 4; i++) begin
            int d;
            d = (p > e[i]) ? p - e[i] : e[i] - p;
            if (d <= (e[i] >> TOL_SHIFT)) return i + 1;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A rising edge closes the previous period; it reports only if armed and not stalled.
    task automatic model_edge(input int p, input int h);
        exp_t e;
        if (armed && prev_p <= TIMEOUT) begin
            e.period = prev_p;
            e.rate   = ref_rate(prev_p);
`ifdef BLINK_RATE_METER_DUTY_EN
            e.high   = prev_h;
`else
            e.high   = 0;
`endif
            q.push_back(e);
        end
        armed  = 1'b1;
        prev_p = p;
        prev_h = h;
    endtask

    task automatic drive_period(input int h, input int l);
        model_edge(h + l, h);
        sig = 1'b1;
        repeat (h) @(posedge clk);
        #1 sig = 1'b0;
        repeat (l) @(posedge clk);
        #1;
        if (h + l >= TIMEOUT + 8) begin
            check("timeout_level", int'(o_timeout), 1);
            check("timeout_period", int'(o_period), 0);
            check("timeout_rate", int'(o_rate), 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, int'(o_period), 0);
        check({tag, "_rate"}, int'(o_rate), 0);
        check({tag, "_valid"}, int'(o_valid), 0);
        check({tag, "_timeout"}, int'(o_timeout), 0);
        check({tag, "_high"}, int'(o_high_time), 0);
    endtask

    task automatic do_reset(input bit level, input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        sig = level;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst   = 1'b0;
        armed = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected report
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            check("valid_expected", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("period", int'(o_period), e.period);
                check("rate", int'(o_rate), e.rate);
                check("timeout_clear", int'(o_timeout), 0);
                check("high_time", int'(o_high_time), e.high);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("init");
        rst = 1'b0;

        repeat (4) drive_period(5, 5);
        drive_period(25, 25);
        drive_period(26, 26);
        drive_period(35, 35);
        drive_period(10, 10);
        drive_period(2, 248);
        drive_period(50, 50);
        drive_period(10, 10);

        repeat (3) drive_period(10, 10);
        do_reset(1'b0, 1);
        repeat (2) drive_period(10, 10);

        do_reset(1'b1, 2);
        repeat (3) drive_period(10, 10);

        repeat (3) drive_period(3, 7);

        drive_period(100, 100);
        drive_period(100, 101);
        drive_period(5, 5);

        for (int n = 0; n < 40; n++) begin
            int sel, p, e, tol, h;
            sel = $urandom_range(0, 5);
            if (sel < 4) begin
                e   = (sel == 0) ? 2*C10 : (sel == 1) ? 2*C5 : (sel == 2) ? 2*C2 : 2*C1;
                tol = e >> TOL_SHIFT;
                p   = e - tol - 1 + $urandom_range(0, 2*tol + 2);
            end else if (sel == 4) begin
                p = $urandom_range(4, 220);
            end else begin
                p = $urandom_range(195, 215);
            end
            h = $urandom_range(2, p - 2);
            drive_period(h, p - h);
        end

        repeat (2) drive_period(5, 5);
        repeat (10) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
